// File: rtl/systolic_array_param_if.sv
// Operand stream, control and result-read bundle for systolic_array_param.
// Pure wiring, no latency.
// in_ready is the only flow-control return. The operand source waits on it.
interface systolic_array_param_if #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int K_MAX = 16,
    localparam int KW   = $clog2(K_MAX + 1),
    localparam int AW   = 2 * DW + $clog2(K_MAX),
    localparam int IW   = (N < 2) ? 1 : $clog2(N)
);
    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              busy;
    logic              done;
    logic [IW-1:0]     rd_row;
    logic [IW-1:0]     rd_col;
    logic [AW-1:0]     rd_data;

    modport master (
        output start, k_len, in_valid, a_col, b_row, rd_row, rd_col,
        input  in_ready, busy, done, rd_data
    );

    modport slave (
        input  start, k_len, in_valid, a_col, b_row, rd_row, rd_col,
        output in_ready, busy, done, rd_data
    );
endinterface

// File: rtl/systolic_array_param.sv
// Output-stationary NxN systolic multiplier: C = A[NxK] x B[KxN], with runtime K.
// Latency: the last accepted beat reaches the final PE after 2N-1 cycles, then done pulses. Reads take 1 cycle.
// Backpressure: in_ready is high only in LOAD. Idle in_valid cycles inject bubbles and only delay completion.
module systolic_array_param #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int K_MAX = 16,
    localparam int KW   = $clog2(K_MAX + 1),
    localparam int AW   = 2 * DW + $clog2(K_MAX),
    localparam int IW   = (N < 2) ? 1 : $clog2(N),
    localparam int CW   = $clog2(2 * N)
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_array_param_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_clear;
    logic              w_done_set;
    logic              w_beat;
    logic [KW-1:0]     w_k;
    logic [KW-1:0]     r_beats;
    logic [CW-1:0]     r_drain;
    logic              r_done;

    // Skew lines. Row i of A uses stages 0..i. Column j of B uses stages 0..j.
    logic signed [DW-1:0] r_ska  [N][N];
    logic                 r_skat [N][N];
    logic signed [DW-1:0] r_skb  [N][N];

    // PE state: forwarded operands, forwarded tag, and the stationary accumulator.
    logic signed [DW-1:0]   r_a   [N][N];
    logic                   r_at  [N][N];
    logic signed [DW-1:0]   r_b   [N][N];
    logic signed [AW-1:0]   r_acc [N][N];

    logic signed [DW-1:0]   w_ain  [N][N];
    logic                   w_at   [N][N];
    logic signed [DW-1:0]   w_bin  [N][N];
    logic signed [2*DW-1:0] w_prod [N][N];

    logic [AW-1:0]     w_rd;
    logic [AW-1:0]     r_rd_data;

    assign w_k = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, accumulator clear, done request and beat acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_done_set  = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_clear = 1'b1;
                    if (w_k == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_set  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    w_beat = 1'b1;
                    if (r_beats == KW'(1)) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == CW'(2 * N - 2)) begin
                    w_state_nxt = S_DONE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat and drain counters, plus the registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beats <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_clear)     r_beats <= w_k;
            else if (w_beat) r_beats <= r_beats - KW'(1);
            if (r_state == S_DRAIN) r_drain <= r_drain + CW'(1);
            else                    r_drain <= '0;
        end
    end

    // Input skew: load stage 0 with the beat (or a zero bubble), then shift
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                for (int d = 0; d < N; d++) begin
                    r_ska[i][d]  <= '0;
                    r_skat[i][d] <= 1'b0;
                    r_skb[i][d]  <= '0;
                end
            end else begin
                r_ska[i][0]  <= w_beat ? bus.a_col[i*DW +: DW] : '0;
                r_skat[i][0] <= w_beat;
                r_skb[i][0]  <= w_beat ? bus.b_row[i*DW +: DW] : '0;
                for (int d = 1; d < N; d++) begin
                    r_ska[i][d]  <= r_ska[i][d-1];
                    r_skat[i][d] <= r_skat[i][d-1];
                    r_skb[i][d]  <= r_skb[i][d-1];
                end
            end
        end
    end

    // PE operand routing: the edge PEs take the skew outputs, the others take their neighbours
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gj == 0) begin : g_left
                assign w_ain[gi][gj] = r_ska[gi][gi];
                assign w_at[gi][gj]  = r_skat[gi][gi];
            end else begin : g_inner_a
                assign w_ain[gi][gj] = r_a[gi][gj-1];
                assign w_at[gi][gj]  = r_at[gi][gj-1];
            end
            if (gi == 0) begin : g_top
                assign w_bin[gi][gj] = r_skb[gj][gj];
            end else begin : g_inner_b
                assign w_bin[gi][gj] = r_b[gi-1][gj];
            end
            assign w_prod[gi][gj] = (2*DW)'(w_ain[gi][gj]) * (2*DW)'(w_bin[gi][gj]);
        end
    end

    // PE array: forward operands every cycle, accumulate only on tagged beats
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst) begin
                    r_a[i][j]   <= '0;
                    r_at[i][j]  <= 1'b0;
                    r_b[i][j]   <= '0;
                    r_acc[i][j] <= '0;
                end else begin
                    r_a[i][j]  <= w_ain[i][j];
                    r_at[i][j] <= w_at[i][j];
                    r_b[i][j]  <= w_bin[i][j];
                    if (w_clear)
                        r_acc[i][j] <= '0;
                    else if (w_at[i][j])
                        r_acc[i][j] <= r_acc[i][j] + AW'(w_prod[i][j]);
                end
            end
        end
    end

    // Result mux. An address outside the array selects nothing and reads 0.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (bus.rd_row == IW'(i) && bus.rd_col == IW'(j))
                    w_rd = r_acc[i][j];
    end

    // Registered read port, active in every state
    always_ff @(posedge clk) begin
        if (rst) r_rd_data <= '0;
        else     r_rd_data <= w_rd;
    end

    assign bus.in_ready = (r_state == S_LOAD);
    assign bus.busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;

endmodule
